// File: rtl/spi_word_loader.sv
// Serial word loader: shifts NWORDS table words MSB-first on sdo/sclk and pulses le high between words.
// Optional macro SPI_LOADER_AUTOSTART_EN runs one sequence automatically on the first edge after reset release.
`timescale 1ns/1ps
module spi_word_loader #(
  parameter int WIDTH     = 24,
  parameter int NWORDS    = 8,
  parameter int DIV       = 8,
  parameter int LE_CYCLES = 4,
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             start,
  input  logic [WIDTH-1:0] word_data,
  output logic [AW-1:0]    word_addr,
  output logic             busy,
  output logic             done,
  output logic             sdo,
  output logic             sclk,
  output logic             le
);

  localparam int BW = $clog2(WIDTH);
  localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_TOP   = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [HW-1:0] HALF_TOP  = HW'(DIV - 1);
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);
  localparam logic [GW-1:0] GAP_TOP   = GW'(LE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NWORDS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [HW-1:0]    r_half_cnt;
  logic             r_phase;
  logic [BW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [AW-1:0]    r_addr;
  logic             r_sclk, r_sdo, r_le, r_busy, r_done;

  logic w_start, w_half_end, w_bit_end, w_last_bit, w_gap_end;
  logic w_phase_nxt, w_sclk_nxt, w_sdo_nxt, w_le_nxt, w_busy_nxt, w_done_nxt;

`ifdef SPI_LOADER_AUTOSTART_EN
  logic r_auto;

  // Armed by reset, consumed by the first edge after release.
  always_ff @(posedge clk) begin
    if (!rset) begin
      r_auto <= 1'b1;
    end else begin
      r_auto <= 1'b0;
    end
  end

  assign w_start = start | r_auto;
`else
  assign w_start = start;
`endif

  assign w_half_end = (r_half_cnt == HALF_TOP);
  assign w_bit_end  = w_half_end & r_phase;
  assign w_last_bit = (r_bit_cnt == {BW{1'b0}});
  assign w_gap_end  = (r_gap_cnt == GAP_TOP);

  // State register.
  always_ff @(posedge clk) begin
    if (!rset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_LOAD;
        else         w_state_nxt = S_IDLE;
      end
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_bit_end && w_last_bit) w_state_nxt = S_LATCH;
        else                         w_state_nxt = S_SHIFT;
      end
      S_LATCH: begin
        if (w_half_end) w_state_nxt = S_GAP;
        else            w_state_nxt = S_LATCH;
      end
      S_GAP: begin
        if (!w_gap_end)                w_state_nxt = S_GAP;
        else if (r_addr < ADDR_LAST)   w_state_nxt = S_LOAD;
        else                           w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    w_phase_nxt = 1'b0;
    w_sdo_nxt   = r_sdo;
    if (r_state == S_SHIFT) begin
      if (w_half_end) w_phase_nxt = ~r_phase;
      else            w_phase_nxt = r_phase;
    end else begin
      w_phase_nxt = 1'b0;
    end
    w_sclk_nxt = (w_state_nxt == S_SHIFT) & w_phase_nxt;
    w_le_nxt   = !((w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) || (w_state_nxt == S_LATCH));
    w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) ||
                 (w_state_nxt == S_LATCH) || (w_state_nxt == S_GAP);
    w_done_nxt = (w_state_nxt == S_DONE);
    // New bits appear only at the start of a low phase; sdo is forced low outside shifting.
    case (w_state_nxt)
      S_SHIFT: begin
        if (r_state == S_LOAD) w_sdo_nxt = word_data[WIDTH-1];
        else if (w_bit_end)    w_sdo_nxt = r_shift[WIDTH-2];
        else                   w_sdo_nxt = r_sdo;
      end
      S_LATCH: w_sdo_nxt = r_sdo;
      default: w_sdo_nxt = 1'b0;
    endcase
  end

  // Counters, shift register and table address.
  always_ff @(posedge clk) begin
    if (!rset) begin
      r_half_cnt <= {HW{1'b0}};
      r_phase    <= 1'b0;
      r_bit_cnt  <= {BW{1'b0}};
      r_gap_cnt  <= {GW{1'b0}};
      r_shift    <= {WIDTH{1'b0}};
      r_addr     <= {AW{1'b0}};
    end else begin
      r_phase <= w_phase_nxt;
      case (r_state)
        S_SHIFT, S_LATCH: r_half_cnt <= w_half_end ? {HW{1'b0}} : (r_half_cnt + HALF_ONE);
        default:          r_half_cnt <= {HW{1'b0}};
      endcase
      case (r_state)
        S_LOAD: begin
          r_bit_cnt <= BIT_TOP;
          r_shift   <= word_data;
        end
        S_SHIFT: begin
          if (w_bit_end && !w_last_bit) begin
            r_bit_cnt <= r_bit_cnt - BIT_ONE;
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          end else begin
            r_bit_cnt <= r_bit_cnt;
            r_shift   <= r_shift;
          end
        end
        default: begin
          r_bit_cnt <= {BW{1'b0}};
          r_shift   <= r_shift;
        end
      endcase
      if (r_state == S_GAP) r_gap_cnt <= w_gap_end ? {GW{1'b0}} : (r_gap_cnt + GAP_ONE);
      else                  r_gap_cnt <= {GW{1'b0}};
      if ((r_state == S_IDLE) && (w_state_nxt == S_LOAD))     r_addr <= {AW{1'b0}};
      else if ((r_state == S_GAP) && (w_state_nxt == S_LOAD)) r_addr <= r_addr + ADDR_ONE;
      else                                                    r_addr <= r_addr;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rset) begin
      r_sclk <= 1'b0;
      r_sdo  <= 1'b0;
      r_le   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_sclk <= w_sclk_nxt;
      r_sdo  <= w_sdo_nxt;
      r_le   <= w_le_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign word_addr = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sdo       = r_sdo;
  assign sclk      = r_sclk;
  assign le        = r_le;

endmodule

// File: tb/tb_spi_word_loader.sv
// Self-checking bench for spi_word_loader: reference model derives bit order and timing from the table.
`timescale 1ns/1ps
module tb_spi_word_loader;
  localparam int W = 8, NW = 2, D = 2, LEC = 2;
  localparam int SEQ_CYC = NW * (1 + 2*D*W + D + LEC);
`ifdef SPI_LOADER_AUTOSTART_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic rset, start, start_b;
  logic [W-1:0] tbl [NW];
  logic [W-1:0] word_data;
  logic [0:0] word_addr;
  logic busy, done, sdo, sclk, le;
  logic [1:0] tbl_b;
  logic [0:0] addr_b;
  logic busy_b, done_b, sdo_b, sclk_b, le_b;

  always #5 clk = ~clk;
  assign word_data = tbl[word_addr];

  spi_word_loader #(.WIDTH(W), .NWORDS(NW), .DIV(D), .LE_CYCLES(LEC)) u_dut (
    .clk(clk), .rset(rset), .start(start), .word_data(word_data), .word_addr(word_addr),
    .busy(busy), .done(done), .sdo(sdo), .sclk(sclk), .le(le));

  spi_word_loader #(.WIDTH(2), .NWORDS(1), .DIV(1), .LE_CYCLES(1)) u_dut_b (
    .clk(clk), .rset(rset), .start(start_b), .word_data(tbl_b), .word_addr(addr_b),
    .busy(busy_b), .done(done_b), .sdo(sdo_b), .sclk(sclk_b), .le(le_b));

  // Observation of the main instance on the falling edge.
  int ncyc = 0, le_rises = 0, busy_cycles = 0, sdo_le_viol = 0, sdo_hi_chg = 0, done_busy_viol = 0;
  bit got_bits[$];
  int done_q[$];
  int busy_rise_q[$];
  logic p_sclk = 1'b0, p_le = 1'b1, p_busy = 1'b0, p_sdo = 1'b0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (sclk === 1'b1 && p_sclk === 1'b0) got_bits.push_back(sdo);
    if (le === 1'b1 && p_le === 1'b0) le_rises <= le_rises + 1;
    if (le === 1'b1 && sdo === 1'b1) sdo_le_viol <= sdo_le_viol + 1;
    if (sclk === 1'b1 && sdo !== p_sdo) sdo_hi_chg <= sdo_hi_chg + 1;
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (busy === 1'b1 && p_busy === 1'b0) busy_rise_q.push_back(ncyc);
    if (done === 1'b1) begin
      done_q.push_back(ncyc);
      if (busy === 1'b1) done_busy_viol <= done_busy_viol + 1;
    end
    p_sclk <= sclk;
    p_le   <= le;
    p_busy <= busy;
    p_sdo  <= sdo;
  end

  int n_cmp = 0, n_fail = 0;
  int b_bits, b_le, b_done, b_busy, b_rise, b_viol, b_hichg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_bits = got_bits.size(); b_le = le_rises; b_done = done_q.size(); b_busy = busy_cycles;
    b_rise = busy_rise_q.size(); b_viol = sdo_le_viol; b_hichg = sdo_hi_chg;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k = 0;
    while ((done_q.size() - b_done) < n && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, ".done_seen"}, 64'((done_q.size() - b_done) >= n), 64'(1));
  endtask

  // Compares everything observed since snap() against nseq complete sequences of the current table.
  task automatic verify(input string tag, input int nseq);
    logic [63:0] exp_v, got_v;
    exp_v = 64'd0;
    got_v = 64'd0;
    for (int s = 0; s < nseq; s++)
      for (int w = 0; w < NW; w++) exp_v = (exp_v << W) | 64'(tbl[w]);
    for (int i = b_bits; i < got_bits.size(); i++) got_v = (got_v << 1) | 64'(got_bits[i]);
    check({tag, ".nbits"},    64'(got_bits.size() - b_bits), 64'(nseq*NW*W));
    check({tag, ".bits"},     got_v, exp_v);
    check({tag, ".le_rises"}, 64'(le_rises - b_le), 64'(nseq*NW));
    check({tag, ".dones"},    64'(done_q.size() - b_done), 64'(nseq));
    check({tag, ".busy_cyc"}, 64'(busy_cycles - b_busy), 64'(nseq*SEQ_CYC));
    check({tag, ".sdo_le"},   64'(sdo_le_viol - b_viol), 64'(0));
    check({tag, ".sdo_hi"},   64'(sdo_hi_chg - b_hichg), 64'(0));
    for (int s = 0; s < nseq && (b_done+s) < done_q.size() && (b_rise+s) < busy_rise_q.size(); s++)
      check({tag, ".latency"}, 64'(done_q[b_done+s] - busy_rise_q[b_rise+s]), 64'(SEQ_CYC));
  endtask

  initial begin
    logic [63:0] v;
    int k, dat, dcnt, aviol, nb;
    logic [1:0] bb;
    logic pb;

    rset = 1'b0; start = 1'b0; start_b = 1'b0;
    tbl[0] = 8'hA5; tbl[1] = 8'h3C; tbl_b = 2'b10;
    tick(2);
    check("rst.sclk", 64'(sclk), 64'(0));
    check("rst.sdo",  64'(sdo),  64'(0));
    check("rst.le",   64'(le),   64'(1));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.addr", 64'(word_addr), 64'(0));
    rset = 1'b1;
    tick(1 + AUTO*200);

    // Reference table, single start pulse.
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    wait_done("t1", 1, 300);
    check("t1.addr_hold", 64'(word_addr), 64'(NW-1));
    tick(10);
    verify("t1", 1);

    // Second start pulse while busy is ignored.
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    tick(19);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done("t2", 1, 300);
    tick(20);
    verify("t2", 1);

    // Reset during the high phase of the fifth bit of word 0.
    tbl[0] = 8'($urandom); tbl[1] = 8'($urandom);
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    tick(19);
    check("t3.pre_sclk", 64'(sclk), 64'(1));
    rset = 1'b0; tick(1);
    check("t3.sclk", 64'(sclk), 64'(0));
    check("t3.sdo",  64'(sdo),  64'(0));
    check("t3.le",   64'(le),   64'(1));
    check("t3.busy", 64'(busy), 64'(0));
    check("t3.addr", 64'(word_addr), 64'(0));
    rset = 1'b1;
    tick(200);
    check("t3.nbits", 64'(got_bits.size() - b_bits), 64'(5 + AUTO*NW*W));
    v = 64'd0;
    for (int i = 0; i < 5 && (b_bits+i) < got_bits.size(); i++) v = (v << 1) | 64'(got_bits[b_bits+i]);
    check("t3.bits", v, 64'(tbl[0] >> 3));
    check("t3.dones", 64'(done_q.size() - b_done), 64'(AUTO));

    // Start held high: back-to-back sequences one idle cycle apart.
    tbl[0] = 8'($urandom); tbl[1] = 8'($urandom);
    snap();
    start = 1'b1;
    k = 0;
    while ((done_q.size() - b_done) < 3 && k < 400) begin
      tick(1);
      k++;
    end
    start = 1'b0;
    check("t4.done_seen", 64'((done_q.size() - b_done) >= 3), 64'(1));
    tick(20);
    verify("t4", 3);
    for (int s = 0; s < 2 && (b_rise+s+1) < busy_rise_q.size() && (b_done+s) < done_q.size(); s++)
      check("t4.gap", 64'(busy_rise_q[b_rise+s+1] - done_q[b_done+s]), 64'(2));

    // Random tables, idle delays and stray start pulses.
    for (int it = 0; it < 4; it++) begin
      tbl[0] = 8'($urandom); tbl[1] = 8'($urandom);
      snap();
      tick(int'($urandom_range(0, 5)));
      start = 1'b1; tick(1); start = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        tick(int'($urandom_range(2, 60)));
        start = 1'b1; tick(1); start = 1'b0;
      end
      wait_done("t5", 1, 300);
      tick(10);
      verify("t5", 1);
    end

    // Minimal configuration: one 2-bit word, DIV=1, LE_CYCLES=1.
    tbl_b = 2'($urandom_range(0, 3));
    start_b = 1'b1; tick(1); start_b = 1'b0;
    check("t6.busy", 64'(busy_b), 64'(1));
    check("t6.le",   64'(le_b),   64'(0));
    dat = -1; dcnt = 0; aviol = 0; nb = 0; bb = 2'b00; pb = sclk_b;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (sclk_b === 1'b1 && pb === 1'b0) begin
        bb = {bb[0], sdo_b};
        nb++;
      end
      pb = sclk_b;
      if (done_b === 1'b1) begin
        dcnt++;
        if (dat < 0) dat = i;
        if (busy_b !== 1'b0) aviol++;
      end
      if (addr_b !== 1'b0) aviol++;
    end
    check("t6.latency", 64'(dat), 64'(7));
    check("t6.dones", 64'(dcnt), 64'(1));
    check("t6.nbits", 64'(nb), 64'(2));
    check("t6.bits", 64'(bb), 64'(tbl_b));
    check("t6.addr_busy", 64'(aviol), 64'(0));

    // Reset release with start low.
    rset = 1'b0; start = 1'b0; tick(1);
    snap();
    rset = 1'b1;
    tick(200);
`ifdef SPI_LOADER_AUTOSTART_EN
    verify("t7", 1);
`else
    check("t7.busy_cyc", 64'(busy_cycles - b_busy), 64'(0));
    check("t7.dones", 64'(done_q.size() - b_done), 64'(0));
    check("t7.busy", 64'(busy), 64'(0));
`endif

    check("glob.sdo_le", 64'(sdo_le_viol), 64'(0));
    check("glob.sdo_hi", 64'(sdo_hi_chg), 64'(0));
    check("glob.done_busy", 64'(done_busy_viol), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_word_loader.md
SPI_WORD_LOADER -- requirements
Module: spi_word_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 24, bits per serial word (WIDTH >= 2).
REQ-002 SHALL have parameter NWORDS, default 8, words per load sequence (NWORDS >= 1).
REQ-003 SHALL have parameter DIV, default 8, clk cycles per sclk half-period (DIV >= 1).
REQ-004 SHALL have parameter LE_CYCLES, default 4, clk cycles le is held high between words (LE_CYCLES >= 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rset, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port start, input, 1, level-sampled request to run one load sequence.
REQ-008 SHALL have port word_data, input, WIDTH, table word addressed by word_addr.
REQ-009 SHALL have port word_addr, output, max(1,clog2(NWORDS)), registered table index.
REQ-010 SHALL have port busy, output, 1, high while a sequence runs.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at sequence end.
REQ-012 SHALL have ports sdo, sclk and le, outputs, 1 each: serial data, serial clock, and latch enable (low while shifting).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH, GAP, DONE.
REQ-014 IDLE: start=1 at an edge SHALL give LOAD next cycle, with word_addr=0 and busy=1.
REQ-015 LOAD: SHALL last 1 cycle; word_data (valid 1 cycle after a word_addr change) is captured into the shift register, le driven 0, sdo = captured MSB.
REQ-016 SHIFT: each bit SHALL take 2*DIV cycles, sclk 0 for DIV then 1 for DIV; sdo changes only while sclk is 0 (at the low-phase start); bits are MSB first.
REQ-017 After the high phase of bit 0 (LSB), SHALL enter LATCH: sclk 0, le 0, for DIV cycles.
REQ-018 GAP: le SHALL be 1 for LE_CYCLES cycles; then, if word_addr < NWORDS-1, word_addr increments and the FSM enters LOAD; otherwise it enters DONE.
REQ-019 Per-word duration SHALL be exactly 1 + 2*DIV*WIDTH + DIV + LE_CYCLES cycles.
REQ-020 DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE; word_addr holds its last value.
REQ-021 start while busy SHALL be ignored (no queueing); start held high through DONE SHALL begin a new sequence from the IDLE cycle after DONE.
REQ-022 sdo SHALL be 0 whenever le=1.
REQ-023 NWORDS=1 SHALL run one word and never increment word_addr.
REQ-024 Bit and half-period counters SHALL never wrap mid-word; counter widths are sized from WIDTH and DIV.

Reset
REQ-025 rset=0 at a clk edge SHALL force, at that edge: state IDLE, sclk=0, sdo=0, le=1, busy=0, done=0, word_addr=0, counters=0, shift register=0.
REQ-026 Reset mid-word SHALL abort with no further sclk edges; le returns to 1 without a latch-completing LATCH phase.
REQ-027 start is ignored in any cycle where rset=0.

Configuration
REQ-028 Macro SPI_LOADER_AUTOSTART_EN defined: the first clk edge with rset=1 after reset SHALL behave as start=1 (one automatic sequence per reset release); later sequences need start.
REQ-029 Macro SPI_LOADER_AUTOSTART_EN undefined: sequences SHALL begin only on start; the block stays in IDLE after reset indefinitely.

Verification (WIDTH=8, NWORDS=2, DIV=2, LE_CYCLES=2, table {0xA5, 0x3C})
REQ-030 One-cycle start pulse -> 8 sclk rising edges per word; sdo sampled at sclk rise = 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; le rises twice; done pulses 74 cycles after LOAD entry; busy high for 74 cycles.
REQ-031 start pulsed again at cycle 20 of a sequence -> ignored; exactly one done pulse, total 74 busy cycles.
REQ-032 rset=0 for 1 cycle during bit 3 of word 0 -> at that edge sclk=0, sdo=0, le=1, busy=0, word_addr=0; no done pulse; no further sclk edges until the next start.
REQ-033 start held high continuously -> back-to-back sequences, each with one done pulse, separated by exactly one IDLE cycle.
REQ-034 NWORDS=1, WIDTH=2, DIV=1, LE_CYCLES=1 with start pulsed -> done pulses 7 cycles after LOAD entry (1+4+1+1); word_addr stays 0.
REQ-035 Build with SPI_LOADER_AUTOSTART_EN and release rset with start=0 -> one full sequence and one done pulse; build without the macro -> busy stays 0 for 200 cycles.
